led_pattern_decoder: RTL and testbench
======================================

Name: led_pattern_decoder

Overview:
Parametrised successor to the board's registered 3-to-8 LED decoder. It drives an active-low LED bank from a SEL_W-bit switch select, qualified by an enable-code match. It adds a prescaled tick plus blink, chase and bar-graph modes alongside the plain decode mode. It sits between the switch/enable pins and the LED pins, and all outputs are registered.

Parameters:
SEL_W, 3, select width; LED count OUT_W = 2**SEL_W (derived localparam, not overridable)
EN_W, 3, enable code width
EN_MATCH, 3'b100, enable code that activates outputs (EN_W bits)
PRESCALE, 4, clk cycles per tick; legal range >= 2
PS_W, $clog2(PRESCALE), prescaler counter width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
enable  input  EN_W  enable code; outputs active only when enable == EN_MATCH
switch  input  SEL_W  LED select, or bar length
mode  input  2  0=DECODE, 1=BLINK, 2=CHASE, 3=BAR
dir  input  1  chase direction: 0=up (pos+1), 1=down (pos-1)
led  output  OUT_W  LED drive, active-low (0 = lit)

Behaviour:
- Reset (async, any time, including mid-pattern): led = all ones; ps_cnt = 0; phase = 0; pos = 0; mode_q = 0. First update occurs on the first posedge after rst deasserts.
- en_ok = (enable == EN_MATCH), full EN_W compare. Any other code blanks led (all ones) on the next edge.
- Prescaler: ps_cnt counts 0..PRESCALE-1 and wraps to 0. tick = (ps_cnt == PRESCALE-1). It runs free regardless of en_ok.
- Mode-change detect: mchg = (mode != mode_q); mode_q <= mode every cycle.
  - On mchg: ps_cnt <= 0, phase <= 1, pos <= switch.
  - mchg overrides a coincident tick; that tick is lost.
- The led update below uses the current mode, phase and pos (pre-update values). Latency is 1 clk from the inputs to led.
  - DECODE: led <= ~(en_ok ? (1 << switch) : 0). Bit-for-bit identical to the legacy decoder.
  - BLINK: phase toggles on tick. led <= ~((en_ok && phase) ? (1 << switch) : 0).
  - CHASE: on tick with en_ok, pos <= pos+1 (dir=0) or pos-1 (dir=1), modulo OUT_W. Wrap: OUT_W-1 goes to 0 up, 0 goes to OUT_W-1 down. With en_ok low, pos freezes and led is blank. led <= ~(en_ok ? (1 << pos) : 0).
  - BAR: led <= ~(en_ok ? ((2 << switch) - 1) : 0).
    - Evaluate in OUT_W+1 bits, then truncate to OUT_W.
    - switch = OUT_W-1 lights all LEDs (led = 0).
    - switch = 0 lights only bit 0.
- switch and dir changes inside a mode take effect at the next edge. In CHASE, switch is sampled only on mode entry.
- Shift operands are sized to OUT_W before shifting. No width-dependent truncation other than the BAR rule.

Decomposition:
- Package led_pattern_pkg holds:
  - typedef enum logic [1:0] led_mode_t {MODE_DECODE, MODE_BLINK, MODE_CHASE, MODE_BAR}
  - localparam default EN_MATCH
  - function onehot_n(sel) returning the OUT_W mask
- One sub-module, led_tick_gen (params PRESCALE, PS_W; ports clk, rst, clr, tick): owns ps_cnt and its clear-on-mchg input.
- Everything else stays in led_pattern_decoder.

Test Plan:
All scenarios use defaults: SEL_W=3, PRESCALE=4.
1. DECODE: enable=3'b100, switch sweeps 0..7 -> led 8'hFE, FD, FB, F7, EF, DF, BF, 7F, each 1 clk after the input. enable=3'b101 -> 8'hFF.
2. Reset mid-chase: mode=2, pulse rst asynchronously between edges -> led=8'hFF immediately. After release, pos=0 and ps_cnt=0.
3. BLINK: mode 0->1 with switch=5, enable=3'b100 -> led=8'hDF for 4 clks, then 8'hFF for 4 clks, and repeats.
4. CHASE wrap: enter mode=2 with switch=6, dir=0 -> led sequence BF, 7F, FE, FD, advancing every 4 clks. Set dir=1 at FE -> FE then 7F.
5. CHASE freeze: drive enable=3'b000 for 10 clks at pos=3 -> led=8'hFF. Restore enable -> 8'hF7, and the walk resumes from pos 3.
6. BAR: mode=3, switch=0 -> 8'hFE; switch=3 -> 8'hF0; switch=7 -> 8'h00. With mode change and tick on the same edge, the next tick arrives 4 clks later.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types, defaults and mask helper for the LED pattern decoder.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BAR    = 2'd3
  } led_mode_t;

  // Enable code that the legacy board decoder responded to.
  localparam logic [2:0] DEFAULT_EN_MATCH = 3'b100;

  // The mask helper works on a fixed wide vector so any select width up
  // to MAX_SEL_W can share it; callers keep the low OUT_W bits.
  localparam int MAX_SEL_W = 9;
  localparam int MAX_OUT_W = 512;

  // Active-low one-hot: bit sel is 0, every other bit is 1.
  function automatic logic [MAX_OUT_W-1:0] onehot_n(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_OUT_W-1:0] one;
    one = {{(MAX_OUT_W-1){1'b0}}, 1'b1};
    onehot_n = ~(one << sel);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every PRESCALE clocks.
// clr restarts the count; a tick that coincides with clr is suppressed so
// the restart wins over the wrap.
module led_tick_gen #(
  parameter int PRESCALE = 4,
  parameter int PS_W     = $clog2(PRESCALE)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt;
  logic            wrap;

  // Terminal count of the prescaler.
  always_comb begin
    wrap = (ps_cnt == LAST);
    tick = wrap && !clr;
  end

  // Count 0..PRESCALE-1, wrapping, or restart from 0 on clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt <= '0;
    end else if (clr || wrap) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_decoder.sv
// Active-low LED bank driver: plain decode, blink, chase and bar-graph
// modes selected by mode, gated by an exact enable-code match. All outputs
// are registered; inputs reach led one clock later.
module led_pattern_decoder
  import led_pattern_pkg::*;
#(
  parameter int              SEL_W    = 3,
  parameter int              EN_W     = 3,
  parameter logic [EN_W-1:0] EN_MATCH = EN_W'(DEFAULT_EN_MATCH),
  parameter int              PRESCALE = 4,
  parameter int              PS_W     = $clog2(PRESCALE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [EN_W-1:0]     enable,
  input  logic [SEL_W-1:0]    switch,
  input  logic [1:0]          mode,
  input  logic                dir,
  output logic [2**SEL_W-1:0] led
);

  localparam int OUT_W = 2**SEL_W;

  led_mode_t        cur_mode;
  led_mode_t        mode_q;
  logic             mchg;
  logic             en_ok;
  logic             tick;
  logic             phase;
  logic             phase_nxt;
  logic [SEL_W-1:0] pos;
  logic [SEL_W-1:0] pos_nxt;
  logic [OUT_W-1:0] led_nxt;

  logic [MAX_OUT_W-1:0] sw_mask_w;
  logic [MAX_OUT_W-1:0] pos_mask_w;
  logic [OUT_W:0]       bar_one;
  logic [OUT_W:0]       bar_inc;
  logic [OUT_W:0]       bar_mask;
  logic                 unused_bits;

  // Decode the mode input, detect a mode change and the enable match.
  always_comb begin
    cur_mode = led_mode_t'(mode);
    mchg     = (cur_mode != mode_q);
    en_ok    = (enable == EN_MATCH);
  end

  led_tick_gen #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (mchg),
    .tick (tick)
  );

  // Pattern masks: active-low one-hots for switch and pos, and the bar
  // fill (2 << switch) - 1 evaluated one bit wider than the LED bank so
  // switch = OUT_W-1 yields all ones before truncation.
  always_comb begin
    sw_mask_w   = onehot_n(MAX_SEL_W'(switch));
    pos_mask_w  = onehot_n(MAX_SEL_W'(pos));
    bar_one     = {{(OUT_W-1){1'b0}}, 2'b10};
    bar_inc     = {{OUT_W{1'b0}}, 1'b1};
    bar_mask    = (bar_one << switch) - bar_inc;
    unused_bits = &{1'b0, sw_mask_w[MAX_OUT_W-1:OUT_W],
                    pos_mask_w[MAX_OUT_W-1:OUT_W], bar_mask[OUT_W]};
  end

  // Next phase/pos: a mode change reloads them and swallows any tick;
  // otherwise blink toggles phase on tick, and chase steps pos on tick
  // only while enabled (modulo OUT_W via natural SEL_W wrap).
  always_comb begin
    phase_nxt = phase;
    pos_nxt   = pos;
    if (mchg) begin
      phase_nxt = 1'b1;
      pos_nxt   = switch;
    end else begin
      if (cur_mode == MODE_BLINK && tick) begin
        phase_nxt = ~phase;
      end
      if (cur_mode == MODE_CHASE && tick && en_ok) begin
        pos_nxt = dir ? (pos - SEL_W'(1)) : (pos + SEL_W'(1));
      end
    end
  end

  // Next LED drive from the current mode and pre-update phase/pos.
  always_comb begin
    led_nxt = '1;
    if (en_ok) begin
      case (cur_mode)
        MODE_DECODE: led_nxt = sw_mask_w[OUT_W-1:0];
        MODE_BLINK:  led_nxt = phase ? sw_mask_w[OUT_W-1:0] : '1;
        MODE_CHASE:  led_nxt = pos_mask_w[OUT_W-1:0];
        MODE_BAR:    led_nxt = ~bar_mask[OUT_W-1:0];
        default:     led_nxt = '1;
      endcase
    end
  end

  // State and output registers; reset blanks the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led    <= '1;
      phase  <= 1'b0;
      pos    <= '0;
      mode_q <= MODE_DECODE;
    end else begin
      led    <= led_nxt;
      phase  <= phase_nxt;
      pos    <= pos_nxt;
      mode_q <= cur_mode;
    end
  end

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed bench for led_pattern_decoder at default parameters
// (SEL_W=3, PRESCALE=4). Inputs change 1 time unit after a rising edge,
// outputs are sampled 1 time unit after the following rising edge.
module tb_led_pattern_decoder;

  logic       clk;
  logic       rst;
  logic [2:0] enable;
  logic [2:0] switch;
  logic [1:0] mode;
  logic       dir;
  logic [7:0] led;

  int checks;
  int failures;

  led_pattern_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .switch (switch),
    .mode   (mode),
    .dir    (dir),
    .led    (led)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (led !== 8'hFF) begin
      failures++;
      $display("FAIL reset_led got=%h exp=%h", led, 8'hFF);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [7:0] exp_tab [8];
    exp_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    mode   = 2'd0;
    enable = 3'b100;
    for (int s = 0; s < 8; s++) begin
      switch = 3'(s);
      step();
      checks++;
      if (led !== exp_tab[s]) begin
        failures++;
        $display("FAIL decode_s%0d got=%h exp=%h", s, led, exp_tab[s]);
      end
    end
    enable = 3'b101;
    step();
    checks++;
    if (led !== 8'hFF) begin
      failures++;
      $display("FAIL decode_bad_enable got=%h exp=%h", led, 8'hFF);
    end
    enable = 3'b100;
  endtask

  task automatic test_blink();
    logic [7:0] exp;
    mode   = 2'd1;
    switch = 3'd5;
    enable = 3'b100;
    step();  // mode-change edge
    for (int i = 0; i < 16; i++) begin
      step();
      exp = (((i / 4) % 2) == 0) ? 8'hDF : 8'hFF;
      checks++;
      if (led !== exp) begin
        failures++;
        $display("FAIL blink_cyc%0d got=%h exp=%h", i, led, exp);
      end
    end
  endtask

  task automatic test_chase_wrap();
    logic [7:0] exp_tab [4];
    exp_tab = '{8'hBF, 8'h7F, 8'hFE, 8'h7F};
    mode   = 2'd2;
    switch = 3'd6;
    dir    = 1'b0;
    step();  // mode-change edge loads pos = 6
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (led !== exp_tab[i / 4]) begin
        failures++;
        $display("FAIL chase_wrap_cyc%0d got=%h exp=%h", i, led, exp_tab[i / 4]);
      end
      if (i == 8) dir = 1'b1;
    end
  endtask

  task automatic test_reset_mid_chase();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 8'hFF) begin
      failures++;
      $display("FAIL rst_async_led got=%h exp=%h", led, 8'hFF);
    end
    checks++;
    if (dut.pos !== 3'd0) begin
      failures++;
      $display("FAIL rst_pos got=%0d exp=%0d", dut.pos, 0);
    end
    checks++;
    if (dut.u_tick.ps_cnt !== 2'd0) begin
      failures++;
      $display("FAIL rst_ps_cnt got=%0d exp=%0d", dut.u_tick.ps_cnt, 0);
    end
    step();
    rst    = 1'b0;
    mode   = 2'd2;
    switch = 3'd6;
    dir    = 1'b0;
    enable = 3'b100;
    step();  // first edge out of reset uses pos = 0
    checks++;
    if (led !== 8'hFE) begin
      failures++;
      $display("FAIL rst_first_edge got=%h exp=%h", led, 8'hFE);
    end
    step();
    checks++;
    if (led !== 8'hBF) begin
      failures++;
      $display("FAIL rst_chase_entry got=%h exp=%h", led, 8'hBF);
    end
  endtask

  task automatic test_chase_freeze();
    int n;
    mode = 2'd0;
    step();
    mode   = 2'd2;
    switch = 3'd3;
    dir    = 1'b0;
    step();  // entry, pos = 3
    step();
    checks++;
    if (led !== 8'hF7) begin
      failures++;
      $display("FAIL freeze_start got=%h exp=%h", led, 8'hF7);
    end
    enable = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (led !== 8'hFF) begin
        failures++;
        $display("FAIL freeze_blank_cyc%0d got=%h exp=%h", i, led, 8'hFF);
      end
    end
    enable = 3'b100;
    step();
    checks++;
    if (led !== 8'hF7) begin
      failures++;
      $display("FAIL freeze_restore got=%h exp=%h", led, 8'hF7);
    end
    n = 0;
    while (led === 8'hF7 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (led !== 8'hEF) begin
      failures++;
      $display("FAIL freeze_resume got=%h exp=%h after %0d cycles", led, 8'hEF, n);
    end
  endtask

  task automatic test_bar();
    mode   = 2'd3;
    switch = 3'd0;
    step();
    checks++;
    if (led !== 8'hFE) begin
      failures++;
      $display("FAIL bar_s0 got=%h exp=%h", led, 8'hFE);
    end
    switch = 3'd3;
    step();
    checks++;
    if (led !== 8'hF0) begin
      failures++;
      $display("FAIL bar_s3 got=%h exp=%h", led, 8'hF0);
    end
    switch = 3'd7;
    step();
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL bar_s7 got=%h exp=%h", led, 8'h00);
    end
    step();
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL bar_s7_hold got=%h exp=%h", led, 8'h00);
    end
    // Next edge is a prescaler tick; change mode onto it.
    mode   = 2'd1;
    switch = 3'd5;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (led !== ((i < 4) ? 8'hDF : 8'hFF)) begin
        failures++;
        $display("FAIL bar_tick_coincide_cyc%0d got=%h exp=%h", i, led,
                 (i < 4) ? 8'hDF : 8'hFF);
      end
    end
  endtask

  // Test sequence and final report.
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    enable   = 3'b000;
    switch   = 3'd0;
    mode     = 2'd0;
    dir      = 1'b0;
    test_reset();
    test_decode();
    test_blink();
    test_chase_wrap();
    test_reset_mid_chase();
    test_chase_freeze();
    test_bar();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
